// File: rtl/axi4_beat_pkg.sv
// axi4_beat_pkg: burst types, FSM states and the AR request record shared by the beat generator.
// Request fields use fixed maximum widths; users slice them down to their own ADDR_W/ID_W.
package axi4_beat_pkg;
  localparam int AR_ID_MAX   = 16;
  localparam int AR_ADDR_MAX = 64;
  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11} burst_e;
  typedef enum logic {IDLE, BURST} state_e;
  typedef struct packed {
    logic [AR_ID_MAX-1:0]   id;
    logic [AR_ADDR_MAX-1:0] addr;
    logic [7:0]             len;
    logic [2:0]             size;
    burst_e                 burst;
  } ar_req_t;
endpackage

// File: rtl/axi4_ar_beat_gen_if.sv
// axi4_ar_beat_gen_if: AR request channel plus per-beat address stream.
interface axi4_ar_beat_gen_if #(parameter int ADDR_W = 32, parameter int ID_W = 4);
  logic              arvalid, arready, arlock;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize, arprot;
  logic [1:0]        arburst;
  logic [3:0]        arcache, arqos, arregion;
  logic              beat_valid, beat_ready, beat_last, beat_err;
  logic [ADDR_W-1:0] beat_addr;
  logic [ID_W-1:0]   beat_id;
  logic [7:0]        beat_idx;
  logic [2:0]        beat_size;
  modport master (output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
                  input arready, input beat_valid, beat_addr, beat_id, beat_idx, beat_size, beat_last, beat_err,
                  output beat_ready);
  modport slave (input arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
                 output arready, output beat_valid, beat_addr, beat_id, beat_idx, beat_size, beat_last, beat_err,
                 input beat_ready);
endinterface

// File: rtl/axi4_ar_fifo.sv
// axi4_ar_fifo: 2-entry FIFO for AR requests; caller must not push when full or pop when empty.
module axi4_ar_fifo #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem_q [2];
  logic         wp_q, rp_q;
  logic [1:0]   cnt_q;
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wp_q  <= wp_q ^ push;
      rp_q  <= rp_q ^ pop;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  assign dout  = mem_q[rp_q];
  assign full  = cnt_q == 2'd2;
  assign empty = cnt_q == 2'd0;
endmodule

// File: rtl/axi4_ar_beat_gen.sv
// axi4_ar_beat_gen: expands an accepted AXI4 AR request into one address beat per handshake.
// AXI4_AR_BEAT_GEN_SKID_EN adds a 2-entry AR FIFO so consecutive bursts run without a gap cycle.
import axi4_beat_pkg::*;
module axi4_ar_beat_gen #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst_n,
  axi4_ar_beat_gen_if.slave bus
);
  localparam int MAX_SIZE = $clog2(DATA_W / 8);
  state_e            state_q, state_d;
  burst_e            mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d, step, wmask, inc, nxt;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        idx_q, idx_d, len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic              err_q, err_d, err_in, req_valid, pop, hs, last, unused_ok;
  ar_req_t           in_req, req;
  assign in_req = '{id: AR_ID_MAX'(bus.arid), addr: AR_ADDR_MAX'(bus.araddr), len: bus.arlen,
                    size: bus.arsize, burst: burst_e'(bus.arburst)};
  assign hs   = bus.beat_valid && bus.beat_ready;
  assign last = state_q == BURST && idx_q == len_q;
`ifdef AXI4_AR_BEAT_GEN_SKID_EN
  logic full, empty;
  axi4_ar_fifo #(.W($bits(ar_req_t))) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(bus.arvalid && !full), .pop(pop),
    .din(in_req), .dout(req), .full(full), .empty(empty)
  );
  assign bus.arready = rst_n && !full;
  assign req_valid   = !empty;
  assign pop         = req_valid && (state_q == IDLE || (hs && last));
`else
  assign req         = in_req;
  assign bus.arready = state_q == IDLE;
  assign req_valid   = bus.arvalid;
  assign pop         = req_valid && state_q == IDLE;
`endif
  assign unused_ok = ^{bus.arlock, bus.arcache, bus.arprot, bus.arqos, bus.arregion, req};
  // Unsupported bursts and oversized beats fall back to INCR and flag every beat.
  assign err_in = req.burst == RSVD || (req.burst == WRAP && !(req.len inside {8'd1, 8'd3, 8'd7, 8'd15}))
                  || int'(req.size) > MAX_SIZE;
  assign step  = ADDR_W'(1) << size_q;
  assign wmask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
  assign inc   = (addr_q & ~(step - ADDR_W'(1))) + step;
  assign nxt   = mode_q == FIXED ? addr_q : mode_q == WRAP ? (addr_q & ~wmask) | (inc & wmask) : inc;
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    id_d    = id_q;
    idx_d   = idx_q;
    len_d   = len_q;
    size_d  = size_q;
    err_d   = err_q;
    if (pop) begin
      state_d = BURST;
      mode_d  = err_in ? INCR : req.burst;
      addr_d  = req.addr[ADDR_W-1:0];
      id_d    = req.id[ID_W-1:0];
      idx_d   = 8'd0;
      len_d   = req.len;
      size_d  = req.size;
      err_d   = err_in;
    end else if (hs && last) begin
      state_d = IDLE;
    end else if (hs) begin
      idx_d  = idx_q + 8'd1;
      addr_d = nxt;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= FIXED;
      addr_q  <= '0;
      id_q    <= '0;
      idx_q   <= 8'd0;
      len_q   <= 8'd0;
      size_q  <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      size_q  <= size_d;
      err_q   <= err_d;
    end
  assign bus.beat_valid = state_q == BURST;
  assign bus.beat_last  = last;
  assign bus.beat_err   = bus.beat_valid && err_q;
  assign bus.beat_addr  = addr_q;
  assign bus.beat_id    = id_q;
  assign bus.beat_idx   = idx_q;
  assign bus.beat_size  = size_q;
endmodule

// File: tb/tb_axi4_ar_beat_gen.sv
// tb_axi4_ar_beat_gen: directed checks of the beat generator in its default (no AR FIFO) build.
module tb_axi4_ar_beat_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cmp = 0;
  int   errs = 0;
  axi4_ar_beat_gen_if #(.ADDR_W(32), .ID_W(4)) bus ();
  axi4_ar_beat_gen #(.ADDR_W(32), .ID_W(4), .DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bt, input logic [3:0] id);
    int n = 0;
    @(negedge clk);
    bus.arvalid = 1'b1; bus.araddr = a; bus.arlen = len; bus.arsize = sz; bus.arburst = bt; bus.arid = id;
    while (bus.arready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("arready", 32'(bus.arready), 32'd1);
    @(posedge clk);
    #1 bus.arvalid = 1'b0;
  endtask
  task automatic beat(input logic [31:0] a, input logic [7:0] i, input logic l, input logic e,
                      input logic [3:0] id, input logic [2:0] sz, input bit stall);
    if (stall) begin
      bus.beat_ready = 1'b0;
      @(negedge clk);
      chk("stall_valid", 32'(bus.beat_valid), 32'd1);
      chk("stall_addr", bus.beat_addr, a);
      chk("stall_idx", 32'(bus.beat_idx), 32'(i));
      chk("stall_last", 32'(bus.beat_last), 32'(l));
      @(posedge clk);
      #1;
    end
    bus.beat_ready = 1'b1;
    @(negedge clk);
    chk("valid", 32'(bus.beat_valid), 32'd1);
    chk("addr", bus.beat_addr, a);
    chk("idx", 32'(bus.beat_idx), 32'(i));
    chk("last", 32'(bus.beat_last), 32'(l));
    chk("err", 32'(bus.beat_err), 32'(e));
    chk("id", 32'(bus.beat_id), 32'(id));
    chk("size", 32'(bus.beat_size), 32'(sz));
    @(posedge clk);
    #1;
  endtask
  task automatic idle_chk();
    @(negedge clk);
    chk("idle_valid", 32'(bus.beat_valid), 32'd0);
    chk("idle_arready", 32'(bus.arready), 32'd1);
  endtask
  initial begin
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arid = '0;
    bus.arlock = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arregion = '0;
    bus.beat_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_arready", 32'(bus.arready), 32'd1);
    chk("rst_valid", 32'(bus.beat_valid), 32'd0);
    chk("rst_last", 32'(bus.beat_last), 32'd0);
    chk("rst_err", 32'(bus.beat_err), 32'd0);
    chk("rst_addr", bus.beat_addr, 32'd0);
    chk("rst_id", 32'(bus.beat_id), 32'd0);
    chk("rst_idx", 32'(bus.beat_idx), 32'd0);
    chk("rst_size", 32'(bus.beat_size), 32'd0);
    rst_n = 1'b1;
    send_ar(32'h1000, 8'd3, 3'd2, 2'b01, 4'd5);
    beat(32'h1000, 8'd0, 1'b0, 1'b0, 4'd5, 3'd2, 1'b0);
    beat(32'h1004, 8'd1, 1'b0, 1'b0, 4'd5, 3'd2, 1'b0);
    beat(32'h1008, 8'd2, 1'b0, 1'b0, 4'd5, 3'd2, 1'b0);
    beat(32'h100C, 8'd3, 1'b1, 1'b0, 4'd5, 3'd2, 1'b0);
    idle_chk();
    send_ar(32'h1003, 8'd1, 3'd2, 2'b01, 4'd6);
    beat(32'h1003, 8'd0, 1'b0, 1'b0, 4'd6, 3'd2, 1'b0);
    beat(32'h1004, 8'd1, 1'b1, 1'b0, 4'd6, 3'd2, 1'b0);
    send_ar(32'h0108, 8'd3, 3'd2, 2'b10, 4'd7);
    beat(32'h0108, 8'd0, 1'b0, 1'b0, 4'd7, 3'd2, 1'b0);
    beat(32'h010C, 8'd1, 1'b0, 1'b0, 4'd7, 3'd2, 1'b0);
    beat(32'h0100, 8'd2, 1'b0, 1'b0, 4'd7, 3'd2, 1'b0);
    beat(32'h0104, 8'd3, 1'b1, 1'b0, 4'd7, 3'd2, 1'b0);
    send_ar(32'h2000, 8'd2, 3'd2, 2'b00, 4'd8);
    beat(32'h2000, 8'd0, 1'b0, 1'b0, 4'd8, 3'd2, 1'b1);
    beat(32'h2000, 8'd1, 1'b0, 1'b0, 4'd8, 3'd2, 1'b1);
    beat(32'h2000, 8'd2, 1'b1, 1'b0, 4'd8, 3'd2, 1'b1);
    idle_chk();
    send_ar(32'h0040, 8'd1, 3'd2, 2'b11, 4'd9);
    beat(32'h0040, 8'd0, 1'b0, 1'b1, 4'd9, 3'd2, 1'b0);
    beat(32'h0044, 8'd1, 1'b1, 1'b1, 4'd9, 3'd2, 1'b0);
    send_ar(32'h0040, 8'd1, 3'd3, 2'b01, 4'd10);
    beat(32'h0040, 8'd0, 1'b0, 1'b1, 4'd10, 3'd3, 1'b0);
    beat(32'h0048, 8'd1, 1'b1, 1'b1, 4'd10, 3'd3, 1'b0);
    send_ar(32'h0044, 8'd2, 3'd2, 2'b10, 4'd11);
    beat(32'h0044, 8'd0, 1'b0, 1'b1, 4'd11, 3'd2, 1'b0);
    beat(32'h0048, 8'd1, 1'b0, 1'b1, 4'd11, 3'd2, 1'b0);
    beat(32'h004C, 8'd2, 1'b1, 1'b1, 4'd11, 3'd2, 1'b0);
    send_ar(32'h3000, 8'd7, 3'd2, 2'b01, 4'd3);
    beat(32'h3000, 8'd0, 1'b0, 1'b0, 4'd3, 3'd2, 1'b0);
    beat(32'h3004, 8'd1, 1'b0, 1'b0, 4'd3, 3'd2, 1'b0);
    beat(32'h3008, 8'd2, 1'b0, 1'b0, 4'd3, 3'd2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(bus.beat_valid), 32'd0);
    chk("rstmid_arready", 32'(bus.arready), 32'd1);
    chk("rstmid_idx", 32'(bus.beat_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(bus.beat_valid), 32'd0);
    idle_chk();
    send_ar(32'h0500, 8'd0, 3'd2, 2'b01, 4'd2);
    beat(32'h0500, 8'd0, 1'b1, 1'b0, 4'd2, 3'd2, 1'b0);
    idle_chk();
    bus.arvalid = 1'b1; bus.araddr = 32'h600; bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arid = 4'd1;
    @(posedge clk);
    #1 bus.araddr = 32'h700; bus.arid = 4'd4;
    @(negedge clk);
    chk("b2b_c1_valid", 32'(bus.beat_valid), 32'd1);
    chk("b2b_c1_addr", bus.beat_addr, 32'h600);
    chk("b2b_c1_last", 32'(bus.beat_last), 32'd1);
    @(negedge clk);
    chk("b2b_c2_valid", 32'(bus.beat_valid), 32'd0);
    chk("b2b_c2_arready", 32'(bus.arready), 32'd1);
    @(posedge clk);
    #1 bus.arvalid = 1'b0;
    @(negedge clk);
    chk("b2b_c3_valid", 32'(bus.beat_valid), 32'd1);
    chk("b2b_c3_addr", bus.beat_addr, 32'h700);
    chk("b2b_c3_id", 32'(bus.beat_id), 32'd4);
    idle_chk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
